// File: rtl/xor_gate.sv
// xor_gate: registered bitwise XOR with a one-cycle valid pipeline and a
// saturating mismatch-bit counter.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset (overrides in_valid and clr)
//   in_valid   accept the (a, b) pair on this edge
//   a, b       operands, WIDTH bits
//   clr        synchronous clear of diff_cnt (applied before the current add)
//   out_valid  c/parity hold a freshly computed result
//   c          registered a ^ b (holds while idle)
//   diff_cnt   saturating accumulated popcount of a ^ b, CNT_W bits
//   parity     registered ^(a ^ b); only when XOR_GATE_PARITY_EN is defined
//
// Parameters: WIDTH >= 1, CNT_W >= clog2(WIDTH+1).
// Optional feature macro: XOR_GATE_PARITY_EN.

module xor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic [CNT_W-1:0] diff_cnt
`ifdef XOR_GATE_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] pop;
    logic [CNT_W-1:0] base;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_next;

    assign diff = a ^ b;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{(CNT_W-1){1'b0}}, diff[i]};
        end
    end

    // Clear takes effect before the current vector is added.
    assign base = clr ? '0 : diff_cnt;

    // One spare bit catches the overflow; pop never exceeds 2^CNT_W-1,
    // so a single carry-out is enough to detect saturation.
    assign sum = {1'b0, base} + {1'b0, pop};

    always_comb begin
        cnt_next = diff_cnt;
        if (in_valid) begin
            cnt_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else if (clr) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            c         <= '0;
            diff_cnt  <= '0;
        end else begin
            out_valid <= in_valid;
            diff_cnt  <= cnt_next;
            if (in_valid) begin
                c <= diff;
            end
        end
    end

`ifdef XOR_GATE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (in_valid) begin
            parity <= ^diff;
        end
    end
`endif

endmodule

// File: tb/tb_xor_gate.sv
// tb_xor_gate: self-checking bench for xor_gate, directed test-plan cases
// plus randomized traffic against a behavioural model.

module tb_xor_gate;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;

    logic        ov1;
    logic [0:0]  c1;
    logic [1:0]  cnt1;
    logic        ov4;
    logic [3:0]  c4;
    logic [15:0] cnt4;
`ifdef XOR_GATE_PARITY_EN
    logic        par1;
    logic        par4;
`endif

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int   m1_c, m1_v, m1_cnt;
    int   m4_c, m4_v, m4_cnt, m4_p, m1_p;

    always #5 clk = ~clk;

    xor_gate #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a4[0:0]),
        .b        (b4[0:0]),
        .clr      (clr),
        .out_valid(ov1),
        .c        (c1),
        .diff_cnt (cnt1)
`ifdef XOR_GATE_PARITY_EN
        ,
        .parity   (par1)
`endif
    );

    xor_gate #(.WIDTH(4), .CNT_W(16)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a4),
        .b        (b4),
        .clr      (clr),
        .out_valid(ov4),
        .c        (c4),
        .diff_cnt (cnt4)
`ifdef XOR_GATE_PARITY_EN
        ,
        .parity   (par4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int acc(input int cnt, input int v, input int cl,
                               input int pc, input int maxv);
        int s;
        s = cl ? 0 : cnt;
        if (v) begin
            s = s + pc;
            if (s > maxv) s = maxv;
        end
        return s;
    endfunction

    // Drive one cycle, advance the model, compare every output.
    task automatic step(input logic r, input logic v, input logic cl,
                        input logic [3:0] av, input logic [3:0] bv);
        int x1, x4;
        rst = r; in_valid = v; clr = cl; a4 = av; b4 = bv;
        x1 = int'(av[0] ^ bv[0]);
        x4 = int'(av ^ bv);
        @(posedge clk);
        if (r) begin
            m1_c = 0; m1_v = 0; m1_cnt = 0; m1_p = 0;
            m4_c = 0; m4_v = 0; m4_cnt = 0; m4_p = 0;
        end else begin
            m1_cnt = acc(m1_cnt, v, cl, x1, 3);
            m4_cnt = acc(m4_cnt, v, cl, $countones(x4), 65535);
            m1_v = v; m4_v = v;
            if (v) begin
                m1_c = x1; m4_c = x4;
                m1_p = x1;
                m4_p = $countones(x4) % 2;
            end
        end
        #1;
        check("m_c1", 32'(c1), 32'(m1_c));
        check("m_ov1", 32'(ov1), 32'(m1_v));
        check("m_cnt1", 32'(cnt1), 32'(m1_cnt));
        check("m_c4", 32'(c4), 32'(m4_c));
        check("m_ov4", 32'(ov4), 32'(m4_v));
        check("m_cnt4", 32'(cnt4), 32'(m4_cnt));
`ifdef XOR_GATE_PARITY_EN
        check("m_par1", 32'(par1), 32'(m1_p));
        check("m_par4", 32'(par4), 32'(m4_p));
`endif
    endtask

    initial begin
        logic [1:0] tt_c [4];
        logic [1:0] tt_n [4];
        tt_c = '{2'd0, 2'd1, 2'd1, 2'd0};
        tt_n = '{2'd0, 2'd1, 2'd2, 2'd2};

        // Reset
        step(1, 1, 0, 4'hF, 4'h0);
        check("rst_c", 32'(c4), 32'h0);
        check("rst_ov", 32'(ov4), 32'h0);
        check("rst_cnt", 32'(cnt4), 32'h0);

        // WIDTH=1 truth table
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            step(0, 1, 0, {3'b0, ab[1]}, {3'b0, ab[0]});
            check("tt_c", 32'(c1), 32'(tt_c[i]));
            check("tt_ov", 32'(ov1), 32'h1);
            check("tt_cnt", 32'(cnt1), 32'(tt_n[i]));
        end

        // Hold
        step(1, 0, 0, 4'h0, 4'h0);
        step(0, 1, 0, 4'h1, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 4'h0, 4'h0);
            check("hold_c", 32'(c1), 32'h1);
            check("hold_ov", 32'(ov1), 32'h0);
            check("hold_cnt", 32'(cnt1), 32'h1);
        end

        // Saturation (CNT_W=2)
        step(1, 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 4'h0, 4'h1);
            check("sat_cnt", 32'(cnt1), (i < 3) ? 32'(i + 1) : 32'h3);
        end

        // Clear collision, then clear alone
        step(0, 1, 1, 4'h1, 4'h0);
        check("clrv_cnt", 32'(cnt1), 32'h1);
        step(0, 0, 1, 4'h0, 4'h0);
        check("clr_cnt", 32'(cnt1), 32'h0);

        // Reset mid-stream
        step(0, 1, 0, 4'h1, 4'h0);
        step(1, 1, 0, 4'h1, 4'h0);
        check("rms_c", 32'(c1), 32'h0);
        check("rms_ov", 32'(ov1), 32'h0);
        check("rms_cnt", 32'(cnt1), 32'h0);
        step(0, 1, 0, 4'h1, 4'h0);
        check("rdeassert_ov", 32'(ov1), 32'h1);

        // WIDTH=4 vectors (parity when enabled)
        step(1, 0, 0, 4'h0, 4'h0);
        step(0, 1, 0, 4'b1010, 4'b0110);
        check("w4_c", 32'(c4), 32'hC);
        check("w4_cnt", 32'(cnt4), 32'h2);
`ifdef XOR_GATE_PARITY_EN
        check("w4_par0", 32'(par4), 32'h0);
`endif
        step(0, 1, 0, 4'b0001, 4'b0000);
        check("w4_c2", 32'(c4), 32'h1);
        check("w4_cnt2", 32'(cnt4), 32'h3);
`ifdef XOR_GATE_PARITY_EN
        check("w4_par1", 32'(par4), 32'h1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
